// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port 1-bit frame buffer between display
// scan-out (fixed priority), a FIFO-buffered writer port and a clear-screen
// sequencer that fills every pixel with one colour bit.
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DEPTH      = 307200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] disp_add,
  output logic              disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic              wr_data,
  input  logic              clr_start,
  input  logic              clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_add,
  output logic              mem_wren,
  output logic              mem_wdata,
  input  logic              mem_rdata
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  // One extra bit so DEPTH can equal 2**ADDR_W without wrapping to zero.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADD = ADDR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] fifo_add [FIFO_DEPTH];
  logic              fifo_dat [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_fill;

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              head_in_range;
  logic              clr_slot;
  logic              clr_last;

  logic              vld_p0;
  logic              vld_p1;

  assign fifo_empty    = (count == '0);
  // No bypass: a full FIFO refuses a push even when it pops this cycle.
  assign wr_ready      = ~reset & (count < FULL_CNT) & (state == IDLE);
  assign push          = wr_valid & wr_ready;
  // The display owns the RAM whenever it is active; the FIFO only drains
  // outside the fill phase (it is already empty by then anyway).
  assign pop           = ~disp_active & ~fifo_empty & (state != CLEAR);
  assign head_in_range = ({1'b0, fifo_add[rd_ptr]} < DEPTH_X);
  assign clr_slot      = (state == CLEAR) & ~disp_active;
  assign clr_last      = clr_slot & (clr_cnt == LAST_ADD);
  assign clr_busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: flush queued writes before the fill so they get overwritten.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clr_start)  state_nxt = FLUSH;
      FLUSH:   if (fifo_empty) state_nxt = CLEAR;
      CLEAR:   if (clr_last)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Clear address counter, restarted from zero while flushing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (state == FLUSH) begin
      clr_cnt <= '0;
    end else if (clr_slot) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Fill colour captured when a clear is accepted.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && clr_start) clr_fill <= clr_data;
  end

  // FIFO storage; contents are meaningless until counted in.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_add[wr_ptr] <= wr_add;
      fifo_dat[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // RAM port slot: display read, clear fill, FIFO write, or idle (address holds).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_add   <= '0;
      mem_wren  <= 1'b0;
      mem_wdata <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      clr_done <= clr_last;
      if (disp_active) begin
        mem_add <= disp_add;
      end else if (clr_slot) begin
        mem_add   <= clr_cnt;
        mem_wdata <= clr_fill;
        mem_wren  <= 1'b1;
      end else if (pop && head_in_range) begin
        mem_add   <= fifo_add[rd_ptr];
        mem_wdata <= fifo_dat[rd_ptr];
        mem_wren  <= 1'b1;
      end
    end
  end

  // Display read return: address registered (p0), RAM data out (p1), captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= 1'b0;
    end else begin
      // p0: read address on mem_add
      vld_p0     <= disp_active;
      // p1: mem_rdata valid
      vld_p1     <= vld_p0;
      // output: capture pixel
      disp_valid <= vld_p1;
      if (vld_p1) disp_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed and random stimulus against a
// transaction-level reference model of the arbitration rules.
module tb_vram_arbiter;

  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int FD    = 4;
  localparam int MSZ   = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          disp_active = 1'b0;
  logic [AW-1:0] disp_add = '0;
  logic          disp_data;
  logic          disp_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_add = '0;
  logic          wr_data = 1'b0;
  logic          clr_start = 1'b0;
  logic          clr_data = 1'b0;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] mem_add;
  logic          mem_wren;
  logic          mem_wdata;
  logic          mem_rdata = 1'b0;

  vram_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset),
    .disp_active(disp_active), .disp_add(disp_add),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_add(wr_add), .wr_data(wr_data),
    .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_add(mem_add), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM, read-first.
  logic ram [MSZ];
  always @(posedge clock) begin
    if (mem_wren) ram[mem_add] <= mem_wdata;
    mem_rdata <= ram[mem_add];
  end

  // Reference model state.
  int q_add[$];
  bit q_dat[$];
  int phase;      // 0 normal, 1 waiting for queue drain, 2 filling
  int cnt;
  bit fill;
  bit ref_mem [MSZ];
  bit exp_wren, exp_wdata, exp_dvalid, exp_ddata, exp_done;
  int exp_add;
  bit p0_v, p0_d, p1_v, p1_d;

  int checks = 0;
  int errors = 0;
  int pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_add.delete();
    q_dat.delete();
    phase = 0; cnt = 0;
    exp_wren = 0; exp_wdata = 0; exp_dvalid = 0; exp_ddata = 0; exp_done = 0;
    exp_add = 0;
    p0_v = 0; p0_d = 0; p1_v = 0; p1_d = 0;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    int sz, pre, a;
    bit acc, d;
    if (reset) begin
      model_reset();
      return;
    end
    sz  = q_add.size();
    pre = phase;
    acc = wr_valid && (sz < FD) && (pre == 0);
    // a pixel read at this edge comes back two edges later
    exp_dvalid = p1_v;
    if (p1_v) exp_ddata = p1_d;
    p1_v = p0_v; p1_d = p0_d;
    p0_v = disp_active;
    p0_d = disp_active ? ref_mem[int'(disp_add)] : 1'b0;
    exp_done = 0;
    exp_wren = 0;
    if (disp_active) begin
      exp_add = int'(disp_add);
    end else if (pre == 2) begin
      exp_add = cnt; exp_wdata = fill; exp_wren = 1; ref_mem[cnt] = fill;
      if (cnt == DEPTH - 1) begin
        phase = 0;
        exp_done = 1;
      end
      cnt++;
    end else if (sz > 0) begin
      a = q_add.pop_front();
      d = q_dat.pop_front();
      if (a < DEPTH) begin
        exp_add = a; exp_wdata = d; exp_wren = 1; ref_mem[a] = d;
      end
    end
    if (pre == 0 && clr_start) begin
      phase = 1;
      fill  = clr_data;
    end else if (pre == 1 && sz == 0) begin
      phase = 2;
      cnt   = 0;
    end
    if (acc) begin
      q_add.push_back(int'(wr_add));
      q_dat.push_back(wr_data);
    end
  endtask

  task automatic check_all();
    chk("mem_wren",   32'(mem_wren),   32'(exp_wren));
    chk("mem_add",    32'(mem_add),    32'(exp_add));
    chk("mem_wdata",  32'(mem_wdata),  32'(exp_wdata));
    chk("disp_valid", 32'(disp_valid), 32'(exp_dvalid));
    chk("disp_data",  32'(disp_data),  32'(exp_ddata));
    chk("clr_done",   32'(clr_done),   32'(exp_done));
    chk("clr_busy",   32'(clr_busy),   32'(phase != 0));
    chk("wr_ready",   32'(wr_ready),   32'(!reset && q_add.size() < FD && phase == 0));
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    disp_active = 0; wr_valid = 0; clr_start = 0;
  endtask

  initial begin
    for (int k = 0; k < MSZ; k++) begin
      ram[k]     = k[0];
      ref_mem[k] = k[0];
    end
    model_reset();
    #1 reset = 1;
    #1;
    check_all();
    step(); step();
    reset = 0;
    step(); step();

    // display-only reads of addresses 0,1,2
    for (int i = 0; i < 3; i++) begin
      disp_active = 1; disp_add = AW'(i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // writes blocked by the display: FIFO fills to FD, then drains
    for (int i = 0; i < 6; i++) begin
      disp_active = 1; disp_add = AW'(i);
      wr_valid = 1; wr_add = AW'(10 + i); wr_data = 1;
      step();
    end
    chk("blocked_ready_low", 32'(wr_ready), 32'(0));
    idle_inputs();
    for (int i = 0; i < 6; i++) step();

    // display toggling every cycle while three writes are queued
    for (int i = 0; i < 10; i++) begin
      disp_active = (i % 2 == 0); disp_add = AW'(10 + i);
      wr_valid = (i < 3); wr_add = AW'(20 + i); wr_data = 0;
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // out-of-range write is dropped, the next one lands
    wr_valid = 1; wr_add = AW'(DEPTH); wr_data = 1; step();
    wr_add = 8'd5; wr_data = 0; step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // random traffic, including occasional clears
    for (int i = 0; i < 700; i++) begin
      disp_active = 1'($urandom_range(0, 1));
      disp_add    = AW'($urandom_range(0, MSZ - 1));
      wr_valid    = 1'($urandom_range(0, 1));
      wr_add      = AW'($urandom_range(0, MSZ - 1));
      wr_data     = 1'($urandom_range(0, 1));
      clr_start   = ($urandom_range(0, 149) == 0);
      clr_data    = 1'($urandom_range(0, 1));
      step();
    end
    idle_inputs();
    for (int i = 0; i < 1000 && (phase != 0 || q_add.size() != 0); i++) step();
    step(); step();

    // directed clear: two queued writes, clear with fill 1, ignored restart
    disp_active = 1; wr_valid = 1; wr_add = 8'd30; wr_data = 0; step();
    wr_add = 8'd31; step();
    wr_valid = 0; disp_active = 0; clr_start = 1; clr_data = 1; step();
    clr_start = 0;
    chk("clr_busy_after_start", 32'(clr_busy), 32'(1));
    pulses = 0;
    for (int i = 0; i < 2000; i++) begin
      disp_active = ($urandom_range(0, 3) == 0);
      disp_add    = AW'($urandom_range(0, DEPTH - 1));
      clr_start   = (i == 50);
      clr_data    = 0;
      wr_valid    = 1; wr_add = AW'(i); wr_data = 0;
      step();
      if (clr_done) pulses++;
      if (!clr_busy && pulses > 0) break;
    end
    idle_inputs();
    chk("clr_done_pulses", 32'(pulses), 32'(1));
    chk("clr_busy_end", 32'(clr_busy), 32'(0));
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 12; i++) begin
      disp_active = 1; disp_add = AW'(i * 13);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // reset during a clear at counter 100
    clr_start = 1; clr_data = 0; step();
    clr_start = 0;
    for (int i = 0; i < 1000 && !(phase == 2 && cnt == 100); i++) step();
    chk("reached_cnt_100", 32'(cnt), 32'(100));
    #2 reset = 1;
    #1;
    chk("arst_mem_add",    32'(mem_add),    32'(0));
    chk("arst_mem_wren",   32'(mem_wren),   32'(0));
    chk("arst_mem_wdata",  32'(mem_wdata),  32'(0));
    chk("arst_disp_data",  32'(disp_data),  32'(0));
    chk("arst_disp_valid", 32'(disp_valid), 32'(0));
    chk("arst_clr_done",   32'(clr_done),   32'(0));
    chk("arst_clr_busy",   32'(clr_busy),   32'(0));
    chk("arst_wr_ready",   32'(wr_ready),   32'(0));
    model_reset();
    step(); step();
    reset = 0;
    #1;
    chk("ready_after_reset", 32'(wr_ready), 32'(1));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (clr_done) pulses++;
    end
    chk("no_done_after_abort", 32'(pulses), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 1-bit video RAM between the display scan-out path, which has fixed priority, and a writer port for drawing logic.
- Also provides a hardware clear-screen sequencer that fills the whole frame buffer with one colour bit.
- Sits between the VGA timing generator (address plus active-video flag) and the on-chip frame buffer RAM.
- Writes use only cycles where the display is not reading.

Parameters:
- ADDR_W, 19, address width of the frame buffer and all address ports.
- DEPTH, 307200, number of pixels (hres*vres). Valid addresses are 0..DEPTH-1.
- FIFO_DEPTH, 4, entries in the write-request FIFO. Must be a power of 2, at least 2.

Ports:
- clock  in  1  system/pixel clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- disp_active  in  1  1 = display needs a read this cycle (active video).
- disp_add  in  ADDR_W  display read address, sampled when disp_active=1.
- disp_data  out  1  pixel read back for the display.
- disp_valid  out  1  1 = disp_data updated this cycle.
- wr_valid  in  1  writer request valid.
- wr_ready  out  1  writer request accepted when wr_valid & wr_ready.
- wr_add  in  ADDR_W  writer address.
- wr_data  in  1  writer pixel value.
- clr_start  in  1  single-cycle clear request.
- clr_data  in  1  fill value for the clear.
- clr_busy  out  1  clear pending or in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- mem_add  out  ADDR_W  RAM address, registered.
- mem_wren  out  1  RAM write enable, registered.
- mem_wdata  out  1  RAM write data, registered.
- mem_rdata  in  1  RAM read data; synchronous RAM, valid 1 cycle after mem_add.

Behaviour:
- Reset values: mem_add=0, mem_wren=0, mem_wdata=0, disp_data=0, disp_valid=0, clr_done=0, clr_busy=0. FIFO is emptied, state=IDLE, clear counter=0.
- Reset mid-clear aborts the clear with no clr_done pulse. FIFO contents are lost.
- States:
  - IDLE: normal arbitration.
  - FLUSH: clear accepted, waiting for the FIFO to drain.
  - CLEAR: fill in progress.
- Transitions:
  - IDLE -> FLUSH on clr_start; clr_data is latched.
  - FLUSH -> CLEAR when the FIFO is empty. This can be the same cycle, i.e. FLUSH lasts at least 1 cycle.
  - CLEAR -> IDLE after the write to address DEPTH-1 is issued; clr_done=1 for that following cycle.
  - clr_start in FLUSH or CLEAR is ignored.
- clr_busy=1 in FLUSH and CLEAR.
- wr_ready = (FIFO count < FIFO_DEPTH) & (state==IDLE), combinational. It is 0 during reset.
  - A pop in the same cycle does not make a full FIFO accept a push; there is no bypass.
- Per-cycle slot priority, decided from current inputs and state:
  - Display slot (disp_active=1): mem_add<=disp_add, mem_wren<=0.
  - CLEAR, display idle: mem_add<=clr counter, mem_wdata<=latched fill, mem_wren<=1. Counter +1.
  - FIFO non-empty (IDLE/FLUSH), display idle: pop the head.
    - If head address < DEPTH: mem_add<=head addr, mem_wdata<=head data, mem_wren<=1.
    - Head address >= DEPTH is popped and dropped with mem_wren<=0.
  - Otherwise: mem_wren<=0, mem_add holds.
- A display slot never writes. The CLEAR counter and the FIFO head stall while disp_active=1.
- Display read latency:
  - disp_add sampled at edge N is presented on mem_add after N.
  - mem_rdata is valid after N+1.
  - disp_data<=mem_rdata at N+2, with disp_valid=1 in that cycle.
  - This uses a 2-stage active-flag pipeline. disp_data holds when disp_valid=0.
- FIFO order is strict: writes reach RAM in acceptance order. Several writes to the same address resolve to the last one.
- A clear overwrites all addresses 0..DEPTH-1 exactly once, including writes accepted before clr_start, because of the flush-first ordering.

Test Plan:
- Display-only: disp_active=1 with disp_add=0,1,2 over 3 cycles and the RAM model holding address k = k[0] -> disp_valid=1 with disp_data=0,1,0 starting 2 cycles later. mem_wren stays 0.
- Blocked writes: wr_valid=1 for 6 cycles (addr 10..15, data 1) while disp_active=1 -> 4 accepted, then wr_ready=0. After disp_active drops, addr 10..13 are written on 4 consecutive cycles and wr_ready returns to 1.
- Interleave: disp_active toggling 1/0 each cycle, 3 queued writes -> writes appear only in the disp_active=0 slots, in order, with no lost or duplicated write.
- Out-of-range: write to addr 307200 then addr 5 -> the first is dropped (mem_wren=0), and addr 5 is written on the next free slot.
- Clear: 2 writes queued, clr_start with clr_data=1 -> the 2 writes issue first, then 307200 fill writes 0..307199. clr_done pulses once and clr_busy falls the same cycle. wr_ready=0 throughout. A second clr_start mid-clear has no effect.
- Reset mid-clear at counter=1000 -> all outputs return to reset values immediately (asynchronous), no clr_done pulse, and wr_ready=1 after reset deasserts.
